// File: rtl/mem_arbiter.sv
// Shares one multi-cycle, single-ported memory between instruction fetch and load/store.
// One access at a time; data wins conflicts, but grants alternate while both keep requesting.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam int unsigned CntW = $clog2(MEM_LAT + 3);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(MEM_LAT + 2);

  state_e              r_state;
  logic                r_owner_d;    // 1: current access belongs to the data side
  logic                r_last_d;     // 1: last grant went to the data side
  logic [CntW-1:0]     r_cnt;
  logic                r_mem_en;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_done;
  logic                r_d_done;
  logic                r_err;

  logic                w_grant_any;
  logic                w_grant_d;
  logic [CntW-1:0]     w_cnt_nxt;

  assign w_grant_any = if_req | d_req;
  // Data wins unless both are requesting and data had the previous grant.
  assign w_grant_d   = d_req & (~if_req | ~r_last_d);
  assign w_cnt_nxt   = r_cnt + CntW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_data   <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant_any) begin
            r_owner_d  <= w_grant_d;
            r_last_d   <= w_grant_d;
            r_mem_en   <= 1'b1;
            r_mem_wr   <= w_grant_d & d_wr;
            r_mem_addr <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d) r_mem_wdata <= d_wdata;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          if (r_mem_wr) begin
            r_d_done <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_state  <= StWait;
          end
        end
        StWait: begin
          r_cnt <= w_cnt_nxt;
          if (mem_valid || (w_cnt_nxt == TimeoutCnt)) begin
            if (r_owner_d) r_d_rdata <= mem_valid ? mem_rdata : '1;
            else           r_if_data <= mem_valid ? mem_rdata : '1;
            if (!mem_valid) r_err <= 1'b1;
            r_d_done  <= r_owner_d;
            r_if_done <= ~r_owner_d;
            r_state   <= StDone;
          end
        end
        StDone: begin
          r_cnt   <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_data   = r_if_data;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign busy      = (r_state != StIdle);
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands/completions are queued by the
// stimulus, a memory model answers reads, and a negedge monitor checks DUT events.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, if_done, d_req, d_wr, d_done;
  logic [15:0] if_addr, if_data, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_wr, mem_valid, busy, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy), .err(err)
  );

  typedef struct {logic [15:0] addr; logic wr; logic [15:0] wdata;} cmd_t;
  typedef struct {logic is_d; logic chk_data; logic [15:0] data; int lat;} done_t;
  typedef struct {logic valid; int delay; logic [15:0] data;} resp_t;

  cmd_t  exp_cmd[$];
  done_t exp_done[$];
  resp_t resp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Monitor
  always @(negedge clk) begin
    cmd_t  c;
    done_t d;
    if (mem_en) begin
      chk("no_issue_while_busy", prev_busy, 1'b0);
      if (exp_cmd.size() == 0) fail_event("unexpected_mem_en");
      else begin
        c = exp_cmd.pop_front();
        chk("mem_addr", mem_addr, c.addr);
        chk("mem_wr", mem_wr, c.wr);
        if (c.wr) chk("mem_wdata", mem_wdata, c.wdata);
      end
      en_cyc = cyc;
    end
    if (if_done || d_done) begin
      chk("single_done", if_done & d_done, 1'b0);
      if (exp_done.size() == 0) fail_event("unexpected_done");
      else begin
        d = exp_done.pop_front();
        chk("done_owner", d_done, d.is_d);
        if (d.chk_data) chk("done_data", d.is_d ? d_rdata : if_data, d.data);
        chk("done_latency", cyc - en_cyc, d.lat);
      end
    end
    if (prev_done) chk("idle_after_done", busy, 1'b0);
    prev_busy = busy;
    prev_done = if_done | d_done;
  end

  // Memory model: answers reads after the queued number of WAIT cycles.
  initial begin
    resp_t r;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && !mem_wr && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (r.valid) begin
          repeat (r.delay) @(negedge clk);
          mem_valid = 1'b1;
          mem_rdata = r.data;
          @(negedge clk);
          mem_valid = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input logic is_d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_done : if_done) && n < 60);
    if (!(is_d ? d_done : if_done)) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected %s done", is_d ? "data" : "fetch");
    end
  endtask

  task automatic fetch(input logic [15:0] a);
    if_addr = a;
    if_req  = 1'b1;
    wait_done(1'b0);
    if_req  = 1'b0;
  endtask

  task automatic data_acc(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    d_addr  = a;
    d_wr    = wr;
    d_wdata = wd;
    d_req   = 1'b1;
    wait_done(1'b1);
    d_req   = 1'b0;
  endtask

  task automatic exp_read(input logic is_d, input logic [15:0] a, input logic [15:0] rd);
    exp_cmd.push_back('{addr: a, wr: 1'b0, wdata: 16'h0});
    resp_q.push_back('{valid: 1'b1, delay: 4, data: rd});
    exp_done.push_back('{is_d: is_d, chk_data: 1'b1, data: rd, lat: 5});
  endtask

  logic [15:0] ld_addr[3] = '{16'h0100, 16'h0101, 16'h0102};
  logic [15:0] ld_data[3] = '{16'hD000, 16'hD001, 16'hD002};
  logic [15:0] fe_addr[3] = '{16'h0020, 16'h0021, 16'h0022};
  logic [15:0] fe_data[3] = '{16'hF000, 16'hF001, 16'hF002};

  initial begin
    int n;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {mem_en, mem_wr, mem_addr, mem_wdata, if_data, d_rdata,
                          if_done, d_done, busy, err}, '0);
    rst = 1'b0;

    // Lone fetch
    exp_read(1'b0, 16'h0010, 16'hB123);
    fetch(16'h0010);

    // Store
    exp_cmd.push_back('{addr: 16'h0200, wr: 1'b1, wdata: 16'hCAFE});
    exp_done.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 16'h0, lat: 1});
    data_acc(1'b1, 16'h0200, 16'hCAFE);

    // Conflict straight after reset: data first
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    exp_read(1'b1, 16'h0040, 16'h1111);
    exp_read(1'b0, 16'h0002, 16'h2222);
    fork
      data_acc(1'b0, 16'h0040, 16'h0);
      fetch(16'h0002);
    join

    // Both held high: D, F, D, F, D, F
    for (int i = 0; i < 3; i++) begin
      exp_read(1'b1, ld_addr[i], ld_data[i]);
      exp_read(1'b0, fe_addr[i], fe_data[i]);
    end
    fork
      for (int i = 0; i < 3; i++) data_acc(1'b0, ld_addr[i], 16'h0);
      for (int j = 0; j < 3; j++) fetch(fe_addr[j]);
    join

    // Timeout on a load, then a normal fetch
    exp_cmd.push_back('{addr: 16'h0300, wr: 1'b0, wdata: 16'h0});
    resp_q.push_back('{valid: 1'b0, delay: 0, data: 16'h0});
    exp_done.push_back('{is_d: 1'b1, chk_data: 1'b1, data: 16'hFFFF, lat: 7});
    data_acc(1'b0, 16'h0300, 16'h0);
    chk("err_after_timeout", err, 1'b1);
    exp_read(1'b0, 16'h0030, 16'h3333);
    fetch(16'h0030);
    chk("err_sticky", err, 1'b1);

    // Reset on the 2nd WAIT cycle of a fetch
    exp_cmd.push_back('{addr: 16'h0044, wr: 1'b0, wdata: 16'h0});
    resp_q.push_back('{valid: 1'b0, delay: 0, data: 16'h0});
    if_addr = 16'h0044;
    if_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_en && n < 20);
    chk("abort_fetch_issued", mem_en, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_mid_wait", {mem_en, mem_wr, mem_addr, mem_wdata, if_data, d_rdata,
                           if_done, d_done, busy, err}, '0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_read(1'b0, 16'h0050, 16'h5555);
    fetch(16'h0050);
    chk("err_clear_after_reset", err, 1'b0);

    repeat (3) @(negedge clk);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
